round_judge: RTL

Synchronous round controller between the computer-player stage (random / Markov / reinforcement players) and the score/outcome/VGA display stage. It synchronises and edge-detects the raw start key, then captures the user's move. It waits for the selected AI player to report ready and captures the AI move. It judges the round, updates two-digit BCD scores, and pulses a redraw request to the screen stage.

---
 rtl/rps_pkg.sv | 30 +++
 rtl/bcd_counter2.sv | 34 +++
 rtl/round_judge.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rps_pkg.sv
// Shared move encodings, round FSM states and the round verdict function.
package rps_pkg;

  localparam logic [1:0] ROCK    = 2'b00;
  localparam logic [1:0] SCISSOR = 2'b01;
  localparam logic [1:0] PAPER   = 2'b10;
  localparam logic [1:0] INVALID = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_AI,
    JUDGE,
    SHOW
  } state_t;

  // Returns {uwin, cwin, equ}; callers screen out INVALID moves beforehand.
  function automatic logic [2:0] judge(input logic [1:0] user_move, input logic [1:0] com_move);
    logic [2:0] verdict;
    if (user_move == com_move)
      verdict = 3'b001;
    else if ((user_move == ROCK    && com_move == SCISSOR) ||
             (user_move == SCISSOR && com_move == PAPER)   ||
             (user_move == PAPER   && com_move == ROCK))
      verdict = 3'b100;
    else
      verdict = 3'b010;
    return verdict;
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD score counter; at 99 it saturates when SCORE_SATURATE_EN is
// defined and wraps to 00 otherwise.
module bcd_counter2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       inc,
  output logic [7:0] score
);

  logic [7:0] score_next;

  always_comb begin
    score_next = score;
    if (score == 8'h99) begin
`ifdef SCORE_SATURATE_EN
      score_next = 8'h99;
`else
      score_next = 8'h00;
`endif
    end else if (score[3:0] == 4'd9) begin
      score_next = {score[7:4] + 4'd1, 4'd0};
    end else begin
      score_next = {score[7:4], score[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      score <= '0;
    else if (inc)
      score <= score_next;
  end

endmodule

// File: rtl/round_judge.sv
// Round controller: synchronises the start key, captures user/AI moves, judges
// the round, keeps BCD scores and requests a redraw. Honours SCORE_SATURATE_EN.
module round_judge
  import rps_pkg::*;
#(
  parameter int unsigned AI_TIMEOUT  = 1024,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start_n,
  input  logic [1:0] user_choice,
  input  logic [1:0] ai_choice,
  input  logic       ai_ready,
  output logic [1:0] user_loaded,
  output logic [1:0] com_loaded,
  output logic [7:0] user_score,
  output logic [7:0] com_score,
  output logic       uwin,
  output logic       cwin,
  output logic       equ,
  output logic       err,
  output logic       draw_req,
  output logic       busy
);

  localparam int unsigned CW = (AI_TIMEOUT > 1) ? $clog2(AI_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(AI_TIMEOUT - 1);

  state_t        state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic          sync_prev;
  logic          start_evt;
  logic [CW-1:0] cnt;
  logic          timeout;
  logic [2:0]    verdict;
  logic          invalid;
  logic          user_inc, com_inc;

  // Chain resets to the key's idle level so reset release cannot fake an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '1;
      sync_prev <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], start_n};
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign start_evt = sync_prev & ~sync_q[SYNC_STAGES-1];
  assign timeout   = (cnt == CNT_LAST);
  assign verdict   = judge(user_loaded, com_loaded);
  assign invalid   = (user_loaded == INVALID) || (com_loaded == INVALID);
  assign user_inc  = (state == JUDGE) && !invalid && verdict[2];
  assign com_inc   = (state == JUDGE) && !invalid && verdict[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_evt) state_next = WAIT_AI;
      WAIT_AI: begin
        if (ai_ready)
          state_next = JUDGE;
        else if (timeout)
          state_next = SHOW;
      end
      JUDGE:   state_next = SHOW;
      SHOW:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    draw_req = (state == SHOW);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      user_loaded <= '0;
      com_loaded  <= '0;
      uwin        <= 1'b0;
      cwin        <= 1'b0;
      equ         <= 1'b0;
      err         <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_evt) begin
            user_loaded <= user_choice;
            uwin        <= 1'b0;
            cwin        <= 1'b0;
            equ         <= 1'b0;
            err         <= 1'b0;
            cnt         <= '0;
          end
        end
        WAIT_AI: begin
          if (ai_ready)
            com_loaded <= ai_choice;
          else if (timeout)
            err <= 1'b1;
          else
            cnt <= cnt + 1'b1;
        end
        JUDGE: begin
          if (invalid)
            err <= 1'b1;
          else
            {uwin, cwin, equ} <= verdict;
        end
        default: ;
      endcase
    end
  end

  bcd_counter2 u_user_score (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (user_inc),
    .score   (user_score)
  );

  bcd_counter2 u_com_score (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (com_inc),
    .score   (com_score)
  );

endmodule
